// File: rtl/hack_bist_pkg.sv
// hack_bist_pkg: shared state encoding and reference truth tables for gate BIST blocks
package hack_bist_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } bist_state_t;
  localparam logic [3:0] EXP_AND  = 4'b1000;
  localparam logic [3:0] EXP_OR   = 4'b1110;
  localparam logic [3:0] EXP_XOR  = 4'b0110;
  localparam logic [3:0] EXP_NAND = 4'b0111;
endpackage

// File: rtl/bist_hold_counter.sv
// bist_hold_counter: counts enabled cycles and pulses expire on the HOLD-th one
module bist_hold_counter #(
  parameter int HOLD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expire
);
  localparam int CW = HOLD > 1 ? $clog2(HOLD) : 1;
  logic [CW-1:0] cnt;
  assign expire = en && cnt == CW'(HOLD - 1);
  // settle counter, restarted whenever the owner leaves its hold phase
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (en) cnt <= expire ? '0 : cnt + 1'b1;
endmodule

// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: walks all input vectors of a gate, checks it against a truth table
module gate_bist_ctrl
  import hack_bist_pkg::*;
#(
  parameter int                    N_IN     = 2,
  parameter logic [(1<<N_IN)-1:0]  EXPECTED = EXP_AND,
  parameter int                    HOLD     = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN-1:0] fail_idx,
  output logic [N_IN:0]   err_count
);
  localparam logic [N_IN:0] LAST = (N_IN+1)'((1 << N_IN) - 1);
  bist_state_t   state;
  logic [N_IN:0] vec;
  logic [N_IN:0] vec_nxt;
  logic          expire;
  logic          mis;
  assign vec_nxt = vec + 1'b1;
  assign mis     = dut_out != EXPECTED[vec[N_IN-1:0]];
  bist_hold_counter #(.HOLD(HOLD)) u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state != APPLY),
    .en    (state == APPLY),
    .expire(expire)
  );
  // sequencer with registered stimulus and result outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      vec       <= '0;
      dut_in    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_idx  <= '0;
      err_count <= '0;
    end else
      case (state)
        IDLE:
          if (start) begin
            state     <= APPLY;
            vec       <= '0;
            dut_in    <= '0;
            busy      <= 1'b1;
            pass      <= 1'b0;
            fail_idx  <= '0;
            err_count <= '0;
          end
        APPLY:
          if (expire) state <= SAMPLE;
        SAMPLE: begin
          if (mis) err_count <= err_count + 1'b1;
          if (mis && err_count == '0) fail_idx <= vec[N_IN-1:0];
          if (vec == LAST) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            dut_in <= '0;
            pass   <= err_count == '0 && !mis;
          end else begin
            state  <= APPLY;
            vec    <= vec_nxt;
            dut_in <= vec_nxt[N_IN-1:0];
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_gate_bist_ctrl.sv
// tb_gate_bist_ctrl: scoreboard bench for gate_bist_ctrl against a behavioural gate model
module tb_gate_bist_ctrl;
  typedef struct {
    int   cyc;
    logic pass;
    int   err;
    int   fidx;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst_n, start, start1;
  int         mode, cyc, n_chk, n_fail;
  logic [1:0] dut_in0, dut_in1, fail_idx0, fail_idx1;
  logic [2:0] err_count0, err_count1;
  logic       busy0, busy1, done0, done1, pass0, pass1;
  exp_t       q0[$], q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic gate_fn(input int m, input int v);
    return m == 0 ? v == 3 : m == 1 ? 1'b0 : v != 3;
  endfunction

  function automatic exp_t model(input int m, input int c);
    exp_t       e;
    logic [3:0] tt;
    tt = 4'b1000;
    e.cyc = c; e.err = 0; e.fidx = 0;
    for (int i = 0; i < 4; i++)
      if (gate_fn(m, i) != tt[i]) begin
        if (e.err == 0) e.fidx = i;
        e.err++;
      end
    e.pass = e.err == 0;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic launch0();
    q0.push_back(model(mode, cyc + 21));
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  gate_bist_ctrl u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_in(dut_in0), .dut_out(gate_fn(mode, int'(dut_in0))),
    .busy(busy0), .done(done0), .pass(pass0), .fail_idx(fail_idx0), .err_count(err_count0)
  );

  gate_bist_ctrl #(.N_IN(2), .EXPECTED(4'b1000), .HOLD(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .dut_in(dut_in1), .dut_out(gate_fn(mode, int'(dut_in1))),
    .busy(busy1), .done(done1), .pass(pass1), .fail_idx(fail_idx1), .err_count(err_count1)
  );

  always @(negedge clk) begin
    exp_t e;
    if (done0) begin
      if (q0.size() == 0) check("u0_spurious_done", 1, 0);
      else begin
        e = q0.pop_front();
        check("u0_done_cycle", cyc, e.cyc);
        check("u0_pass", pass0, e.pass);
        check("u0_err_count", err_count0, e.err);
        check("u0_fail_idx", fail_idx0, e.fidx);
      end
    end
    if (done1) begin
      if (q1.size() == 0) check("u1_spurious_done", 1, 0);
      else begin
        e = q1.pop_front();
        check("u1_done_cycle", cyc, e.cyc);
        check("u1_pass", pass1, e.pass);
        check("u1_err_count", err_count1, e.err);
        check("u1_fail_idx", fail_idx1, e.fidx);
      end
    end
  end

  initial begin
    cyc = 0; n_chk = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; start1 = 1'b0; mode = 0;
    tick(2);
    check("rst_dut_in", dut_in0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_pass", pass0, 0);
    check("rst_fail_idx", fail_idx0, 0);
    check("rst_err_count", err_count0, 0);
    rst_n = 1'b1;
    tick(2);
    launch0();
    for (int k = 0; k < 20; k++) begin
      check("seq_dut_in", dut_in0, k / 5);
      check("seq_busy", busy0, 1);
      tick(1);
    end
    check("done_busy_low", busy0, 0);
    check("done_dut_in_zero", dut_in0, 0);
    tick(5);
    mode = 1;
    launch0();
    tick(25);
    mode = 2;
    launch0();
    tick(25);
    mode = 0;
    launch0();
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(8);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(15);
    check("held_pass", pass0, 1);
    check("held_err_count", err_count0, 0);
    launch0();
    tick(7);
    rst_n = 1'b0;
    #1;
    check("midrst_dut_in", dut_in0, 0);
    check("midrst_busy", busy0, 0);
    check("midrst_done", done0, 0);
    check("midrst_pass", pass0, 0);
    check("midrst_fail_idx", fail_idx0, 0);
    check("midrst_err_count", err_count0, 0);
    q0.delete();
    tick(2);
    rst_n = 1'b1;
    tick(30);
    launch0();
    tick(25);
    for (int j = 0; j < 5; j++) q1.push_back(model(0, cyc + 9 + 10 * j));
    start1 = 1'b1;
    tick(50);
    start1 = 1'b0;
    tick(10);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/gate_bist_ctrl.md
# gate_bist_ctrl

Built-in self-test sequencer for a single-output combinational gate from the base gate library (hAnd, hOr, hXor, etc.). On `start` it walks every input vector of the gate under test. Each vector is held for a programmable settle time, then the gate output is sampled and compared against a parameterised truth table. The block reports pass/fail, the first failing vector, and the mismatch count. It sits beside a gate instance in hardware test wrappers and replaces hand-written stimulus sequences.

## Interface
- `N_IN`, 2: gate input count; 2^N_IN vectors applied (1..4 supported).
- `EXPECTED`, 4'b1000: expected truth table, width 2^N_IN; bit i = expected `dut_out` for `dut_in == i` (default = AND).
- `HOLD`, 4: settle cycles per vector, ≥1.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: run request; sampled only in IDLE.
- `dut_in` out N_IN: stimulus vector driven to gate inputs (bit 0 = `a`, bit 1 = `b`, …).
- `dut_out` in 1: gate output.
- `busy` out 1: high from the cycle after start acceptance through the last SAMPLE cycle.
- `done` out 1: one-cycle pulse in DONE.
- `pass` out 1: 1 when the last run had zero mismatches.
- `fail_idx` out N_IN: first failing vector of the last run; 0 if pass.
- `err_count` out N_IN+1: mismatches in the last run, 0..2^N_IN; no saturation needed.

## Operation
- States: IDLE, APPLY, SAMPLE, DONE.
- IDLE:
  - `dut_in`=0, `busy`=0.
  - `start`=1 → APPLY, vector=0, hold counter=0.
  - On acceptance, `pass`, `fail_idx` and `err_count` clear to 0. `pass` stays 0 until DONE.
- APPLY:
  - `dut_in`=vector.
  - Counter increments each cycle.
  - After HOLD cycles → SAMPLE.
- SAMPLE:
  - `dut_in` still = vector.
  - At the closing edge, compare `dut_out` vs `EXPECTED[vector]`.
  - On mismatch: `err_count`++. If this is the first mismatch, load `fail_idx`=vector.
  - If vector == 2^N_IN−1 → DONE; else vector++ and → APPLY.
- DONE:
  - `done`=1, `busy`=0, `dut_in`=0.
  - `pass` = (`err_count`==0), registered.
  - Unconditionally → IDLE; `start` is ignored in this cycle.
- `start` outside IDLE has no effect; a run cannot be aborted except by reset.
- Vector counter is N_IN+1 bits internally so the terminal compare never wraps.

## Timing
- Reset (async assert, sync release): state IDLE; `dut_in`, `busy`, `done`, `pass`, `fail_idx`, `err_count` all 0.
- Reset asserted mid-run: immediate return to reset values. The partial result is discarded and there is no `done` pulse.
- Start accepted at edge 0 → APPLY begins cycle 1.
- Per vector: HOLD+1 cycles.
- `done` is high in cycle 2^N_IN·(HOLD+1)+1. Defaults: cycle 21.
- Results are valid from the `done` cycle and held until the next start acceptance.
- `start` held continuously: runs repeat with one IDLE cycle between them, a period of 2^N_IN·(HOLD+1)+2 cycles (22 at defaults).
- `dut_out` must settle within HOLD cycles. Combinational gates settle within one cycle, so HOLD=1 is legal.

## Structure
- Shared package `hack_bist_pkg`: state encoding constants (IDLE=2'd0, APPLY=2'd1, SAMPLE=2'd2, DONE=2'd3) and default `EXPECTED` constants for each base gate (AND, OR, XOR, NAND).
- One sub-module, `bist_hold_counter`:
  - Parameter HOLD; inputs `clear`/`en`; output `expire` pulse.
  - Reused by later multi-gate BIST wrappers.
- FSM, vector counter and result registers live in `gate_bist_ctrl`.

## Test plan
- Defaults, DUT = real hAnd, start pulse → `dut_in` sequence 0,1,2,3 for 5 cycles each; `done` at cycle 21; `pass`=1, `err_count`=0, `fail_idx`=0.
- DUT stuck-at-0 → `pass`=0, `err_count`=1, `fail_idx`=3.
- DUT = NAND (inverted) → `err_count`=4, `fail_idx`=0, `pass`=0.
- Start pulsed again at cycles 3 and 12 of a run → ignored; single `done` at cycle 21; results unchanged.
- `rst_n` low at cycle 8 → all outputs 0 immediately, no `done`. A subsequent start gives a full correct run with `done` 21 cycles later.
- `start` held high for 50 cycles, N_IN=2, HOLD=1 → `done` at cycles 9, 19, 29, 39, 49; each run's results correct.
